// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, divider FSM states
// and the signed-overflow operand constant.
package mdu_pkg;

   localparam int WIDTH   = 32;
   localparam int COUNT_W = 5;

   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Two's-complement magnitude; INT_MIN maps to itself, read as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_32_if.sv
// Request/result bundle between the MDU issue logic and the 32-bit divider.
interface div_32_if;
   import mdu_pkg::*;

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             exception;
   logic             ready;
   logic             busy;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, exception, ready, busy
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, exception, ready, busy
   );

endinterface

// File: rtl/div_32_div_step.sv
// One restoring shift-subtract iteration: shifts {R,Q} left, tries R-B and
// keeps the difference when it does not go negative.
module div_step
   import mdu_pkg::*;
(
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // One guard bit above the 33-bit remainder keeps the trial sign unambiguous.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {2'b00, dvs};

   always_comb begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH+1]) begin
         rem_next = trial[WIDTH:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_32.sv
// Sequential 32-bit signed divider: magnitudes are divided with a restoring
// loop one bit per clock, then signs are reapplied in a single fix-up cycle.
//
//   state | meaning
//   IDLE  | waiting for start; divide-by-zero resolves here straight to DONE
//   RUN   | 32 restoring iterations, one quotient bit per clock
//   FIX   | sign correction and overflow override written to outputs
//   DONE  | ready pulse, results valid
module div_32
   import mdu_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   div_32_if.slave  bus
);

   div_state_t state, state_next;

   logic [WIDTH-1:0]   q_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH:0]     r_reg;
   logic [COUNT_W-1:0] count;
   logic               sign_q;
   logic               sign_r;
   logic               ovf;

   logic [WIDTH:0]     r_next;
   logic [WIDTH-1:0]   q_next;

   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic               exception;

   logic               accept;
   logic               div_zero;
   logic               last_iter;

   assign accept    = (state == IDLE) && bus.start;
   assign div_zero  = (bus.divisor == '0);
   assign last_iter = (count == COUNT_W'(WIDTH - 1));

   div_step u_step (
      .rem      (r_reg),
      .quo      (q_reg),
      .dvs      (b_reg),
      .rem_next (r_next),
      .quo_next (q_next)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_next = FIX;
            end
         end
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_reg     <= '0;
         b_reg     <= '0;
         r_reg     <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         ovf       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         exception <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && div_zero) begin
                  quotient  <= '0;
                  remainder <= '0;
                  exception <= 1'b1;
               end else if (accept) begin
                  q_reg  <= abs_val(bus.dividend);
                  b_reg  <= abs_val(bus.divisor);
                  r_reg  <= '0;
                  count  <= '0;
                  sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  sign_r <= bus.dividend[WIDTH-1];
                  ovf    <= (bus.dividend == INT_MIN) && (bus.divisor == '1);
               end
            end
            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               count <= count + 1'b1;
            end
            FIX: begin
               // INT_MIN / -1 is not representable; flag it with a fixed result.
               if (ovf) begin
                  quotient  <= INT_MIN;
                  remainder <= '0;
                  exception <= 1'b1;
               end else begin
                  quotient  <= sign_q ? (~q_reg + 1'b1) : q_reg;
                  remainder <= sign_r ? (~r_reg[WIDTH-1:0] + 1'b1) : r_reg[WIDTH-1:0];
                  exception <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The remainder never reaches 2^32 after a completed pass, so its MSB is dead.
   logic unused_r_msb;
   assign unused_r_msb = r_reg[WIDTH];

   assign bus.quotient  = quotient;
   assign bus.remainder = remainder;
   assign bus.exception = exception;
   assign bus.ready     = (state == DONE);
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: a reference model built on native signed
// division queues expected results at issue time; a monitor retires them on ready.
module tb_div_32;
   import mdu_pkg::*;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        exc;
      int          lat;
      int          issued;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   logic clock       = 1'b0;
   logic reset_n     = 1'b0;
   logic prev_ready  = 1'b0;

   div_32_if bus ();

   div_32 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sd;
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      e.issued = 0;
      if (b == 32'd0) begin
         e.q = 32'd0; e.r = 32'd0; e.exc = 1'b1; e.lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 32'd0; e.exc = 1'b1; e.lat = 34;
      end else begin
         e.q = 32'(sa / sd); e.r = 32'(sa % sd); e.exc = 1'b0; e.lat = 34;
      end
      return e;
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (bus.ready) begin
         check("ready_width", 32'(prev_ready), 32'd0);
         if (sb.size() == 0) begin
            check("spurious_ready", 32'(bus.ready), 32'd0);
         end else begin
            e = sb.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.r);
            check("exception", 32'(bus.exception), 32'(e.exc));
            check("latency", 32'(cyc - e.issued), 32'(e.lat));
         end
      end
      prev_ready = bus.ready;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clock);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      e = model(a, b);
      e.issued = cyc;
      sb.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      check("drain", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clock);
      check("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   logic [31:0] dir_a[11] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'd0, 32'd7, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h7FFF_FFFF};
   logic [31:0] dir_b[11] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF,
                              32'd1, 32'd5, 32'd100, 32'd1,
                              32'h8000_0000, 32'hFFFF_FFFF};

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clock);
      check("rst_quotient", bus.quotient, 32'd0);
      check("rst_remainder", bus.remainder, 32'd0);
      check("rst_exception", 32'(bus.exception), 32'd0);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 11; i++) begin
         issue(dir_a[i], dir_b[i]);
         drain();
      end

      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i % 4 == 1) b = -b;
         issue(a, b);
         drain();
      end

      // start pulses mid-run and during the ready cycle must both be ignored
      issue(32'd100, 32'd7);
      repeat (9) @(negedge clock);
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      for (int i = 0; i < 60 && !bus.ready; i++) @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (4) @(negedge clock);
      check("hold_quotient", bus.quotient, 32'd14);
      check("hold_remainder", bus.remainder, 32'd2);
      check("hold_busy", 32'(bus.busy), 32'd0);
      check("hold_drain", 32'(sb.size()), 32'd0);
      sb.delete();

      // reset in the middle of a run aborts without a ready pulse
      issue(32'd100, 32'd7);
      repeat (14) @(negedge clock);
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("abort_quotient", bus.quotient, 32'd0);
      check("abort_remainder", bus.remainder, 32'd0);
      check("abort_exception", 32'(bus.exception), 32'd0);
      check("abort_ready", 32'(bus.ready), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(negedge clock);
      issue(32'h7FFF_FFFF, 32'h10);
      drain();
      check("post_reset_q", bus.quotient, 32'h07FF_FFFF);
      check("post_reset_r", bus.remainder, 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
